// File: rtl/ternary_seq_pkg.sv
// Shared types and constants for the ternary engine sequencer.
// Holds the FSM encoding, command opcodes, counter widths and the ld_param packing.
package ternary_seq_pkg;

    localparam int IN_BITS    = 4;
    localparam int OUT_BITS   = 3;
    localparam int BEAT_BITS  = OUT_BITS + 1;
    localparam int LD_PARAM_W = IN_BITS + OUT_BITS;

    localparam logic OP_LOAD    = 1'b0;
    localparam logic OP_COMPUTE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LSETTLE,
        ST_CLR,
        ST_COMP,
        ST_DRAIN,
        ST_OUT
    } state_t;

    function automatic logic [LD_PARAM_W-1:0] pack_ld_param(
        input logic [IN_BITS-1:0]  in_len,
        input logic [OUT_BITS-1:0] out_len
    );
        return {in_len, out_len};
    endfunction

endpackage

// File: rtl/ternary_seq_cnt.sv
// Clearable up-counter with terminal compare against a supplied limit.
// Count updates one cycle after i_en; o_at_limit is combinational from the count.
module ternary_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt,
    output logic         o_at_limit
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/ternary_seq_ctrl.sv
// Sequencer steering the shared input stream to the weight loader or the MAC array.
// Stream/loader/MAC strobes are combinational from state; results stall losslessly on res_ready.
module ternary_seq_ctrl
    import ternary_seq_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int DATA_W      = 8,
    parameter int MAC_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    input  logic                          cmd_op,
    input  logic [IN_BITS-1:0]            cmd_in_len,
    input  logic [OUT_BITS-1:0]           cmd_out_len,
    output logic                          cmd_ready,
    input  logic                          s_valid,
    input  logic [MAX_IN_LEN-1:0]         s_data,
    output logic                          s_ready,
    output logic                          ld_ena,
    output logic [MAX_IN_LEN-1:0]         ld_data,
    output logic [LD_PARAM_W-1:0]         ld_param,
    input  logic                          ld_done,
    output logic                          mac_clr,
    output logic                          mac_en,
    output logic [IN_BITS-1:0]            mac_idx,
    output logic signed [DATA_W-1:0]      mac_x,
    output logic [$clog2(MAX_OUT_LEN)-1:0] res_sel,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_last,
    output logic                          weights_valid,
    output logic                          err
);

    localparam int         ROW_W      = $clog2(MAX_OUT_LEN);
    localparam logic [2:0] DRAIN_LAST = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

    state_t r_state;
    state_t w_next;

    logic [IN_BITS-1:0]  r_in_len;
    logic [OUT_BITS-1:0] r_out_len;
    logic                r_weights_valid;
    logic                r_err;
    logic [2:0]          r_drain_cnt;

    logic w_latch;
    logic w_set_wv;
    logic w_clr_wv;
    logic w_err_set;
    logic w_cnt_clr;
    logic w_beat_en;
    logic w_elem_en;
    logic w_row_en;

    logic [BEAT_BITS-1:0] w_beat_cnt;
    logic                 w_beat_last;
    logic [IN_BITS-1:0]   w_elem_cnt;
    logic                 w_elem_last;
    logic [ROW_W-1:0]     w_row_cnt;
    logic                 w_row_last;

    // Two beats per row: the final beat index is 2*out_len+1.
    ternary_seq_cnt #(.W(BEAT_BITS)) u_beat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_en       (w_beat_en),
        .i_limit    ({r_out_len, 1'b1}),
        .o_cnt      (w_beat_cnt),
        .o_at_limit (w_beat_last)
    );

    ternary_seq_cnt #(.W(IN_BITS)) u_elem_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_en       (w_elem_en),
        .i_limit    (r_in_len),
        .o_cnt      (w_elem_cnt),
        .o_at_limit (w_elem_last)
    );

    ternary_seq_cnt #(.W(ROW_W)) u_row_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cnt_clr),
        .i_en       (w_row_en),
        .i_limit    (r_out_len),
        .o_cnt      (w_row_cnt),
        .o_at_limit (w_row_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        s_ready   = 1'b0;
        ld_ena    = 1'b0;
        ld_data   = '0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        mac_idx   = '0;
        mac_x     = '0;
        res_sel   = '0;
        res_valid = 1'b0;
        res_last  = 1'b0;
        w_latch   = 1'b0;
        w_set_wv  = 1'b0;
        w_clr_wv  = 1'b0;
        w_err_set = 1'b0;
        w_cnt_clr = 1'b0;
        w_beat_en = 1'b0;
        w_elem_en = 1'b0;
        w_row_en  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                w_cnt_clr = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD) begin
                        w_latch  = 1'b1;
                        w_clr_wv = 1'b1;
                        w_next   = ST_LOAD;
                    end else if (r_weights_valid) begin
                        w_latch = 1'b1;
                        w_next  = ST_CLR;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                s_ready   = 1'b1;
                ld_ena    = s_valid;
                ld_data   = s_data;
                w_beat_en = s_valid;
                if (s_valid && w_beat_last) begin
                    if (ld_done) begin
                        w_next = ST_LSETTLE;
                    end else begin
                        w_err_set = 1'b1;
                        w_next    = ST_IDLE;
                    end
                end else if (!s_valid && (w_beat_cnt != '0)) begin
                    // The loader needs ld_ena contiguous once the matrix has started.
                    w_err_set = 1'b1;
                    w_next    = ST_IDLE;
                end
            end

            ST_LSETTLE: begin
                w_set_wv = 1'b1;
                w_next   = ST_IDLE;
            end

            ST_CLR: begin
                mac_clr = 1'b1;
                w_next  = ST_COMP;
            end

            ST_COMP: begin
                s_ready   = 1'b1;
                mac_en    = s_valid;
                mac_idx   = w_elem_cnt;
                mac_x     = $signed(s_data[DATA_W-1:0]);
                w_elem_en = s_valid;
                if (s_valid && w_elem_last) begin
                    w_next = (MAC_LAT == 0) ? ST_OUT : ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_next = ST_OUT;
                end
            end

            ST_OUT: begin
                res_valid = 1'b1;
                res_sel   = w_row_cnt;
                res_last  = w_row_last;
                w_row_en  = res_ready;
                if (res_ready && w_row_last) begin
                    w_next = ST_IDLE;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_len        <= '0;
            r_out_len       <= '0;
            r_weights_valid <= 1'b0;
            r_err           <= 1'b0;
            r_drain_cnt     <= '0;
        end else begin
            if (w_latch) begin
                r_in_len  <= cmd_in_len;
                r_out_len <= cmd_out_len;
            end
            if (w_clr_wv) begin
                r_weights_valid <= 1'b0;
            end else if (w_set_wv) begin
                r_weights_valid <= 1'b1;
            end
            r_err <= w_err_set;
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 3'd1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign ld_param      = pack_ld_param(r_in_len, r_out_len);
    assign weights_valid = r_weights_valid;
    assign err           = r_err;

endmodule
